bram_bank_array: RTL and testbench

Parametrised multi-bank block RAM built from NUM_BANKS single-port banks behind one address space, with a selectable read-during-write mode and an optional output pipeline register. A hardware clear engine fills every location with CLEAR_VALUE, either after reset or on request, because FPGA reset does not clear BRAM contents. The block serves as the general on-chip buffer for the power-test accelerators, replacing fixed 2048 x 8 single banks.

---
 rtl/bram_pkg.sv | 21 ++
 rtl/bram_bank_array_if.sv | 28 ++
 rtl/bram_bank_core.sv | 41 ++++
 rtl/bram_bank_array.sv | 141 ++++++++++++++
 tb/tb_bram_bank_array.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/bram_pkg.sv
// rtl/bram_pkg.sv - shared types and helpers for the banked block RAM
package bram_pkg;

  typedef enum logic [1:0] {
    WRITE_FIRST,
    READ_FIRST,
    NO_CHANGE
  } read_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } clr_state_e;

  // A single bank still needs a 1-bit select so the select pipeline has a legal width.
  function automatic int bank_sel_width(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

endpackage

// File: rtl/bram_bank_array_if.sv
// rtl/bram_bank_array_if.sv - access and clear-control bundle of the banked block RAM
interface bram_bank_array_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8
) ();

  logic                  en;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  ready;
  logic                  clear_req;
  logic                  clear_busy;
  logic                  clear_done;

  modport master (
    output en, we, addr, din, clear_req,
    input  dout, dout_valid, ready, clear_busy, clear_done
  );

  modport slave (
    input  en, we, addr, din, clear_req,
    output dout, dout_valid, ready, clear_busy, clear_done
  );

endinterface

// File: rtl/bram_bank_core.sv
// rtl/bram_bank_core.sv - one single-port block RAM bank with selectable read-during-write behaviour
module bram_bank_core
  import bram_pkg::*;
#(
  parameter int         DATA_WIDTH = 8,
  parameter int         DEPTH      = 2048,
  parameter read_mode_e READ_MODE  = WRITE_FIRST,
  localparam int        AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] dout_o
);

  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] dout_q;

  // No reset here: the array and its output latch must map onto a plain BRAM primitive.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= din_i;
      end
      case (READ_MODE)
        WRITE_FIRST: dout_q <= we_i ? din_i : mem_q[addr_i];
        READ_FIRST:  dout_q <= mem_q[addr_i];
        default: begin
          if (!we_i) begin
            dout_q <= mem_q[addr_i];
          end
        end
      endcase
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/bram_bank_array.sv
// rtl/bram_bank_array.sv - multi-bank block RAM with read-mode select, output stage and clear engine
module bram_bank_array
  import bram_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    BANK_DEPTH     = 2048,
  parameter int                    NUM_BANKS      = 4,
  parameter read_mode_e            READ_MODE      = WRITE_FIRST,
  parameter bit                    OUT_REG        = 1'b1,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
  localparam int                   ADDR_WIDTH     = $clog2(NUM_BANKS * BANK_DEPTH),
  localparam int                   OFS_W          = $clog2(BANK_DEPTH),
  localparam int                   BANK_W         = bank_sel_width(NUM_BANKS)
) (
  input  logic             clk,
  input  logic             rst_n,
  bram_bank_array_if.slave bus
);

  localparam clr_state_e RST_STATE = clr_state_e'(CLEAR_ON_RESET ? CLEAR : IDLE);

  clr_state_e            state_q, state_d;
  logic [OFS_W-1:0]      cnt_q, cnt_d;
  logic                  clearing;
  logic                  accept;
  logic [BANK_W-1:0]     bank_sel;
  logic [OFS_W-1:0]      bank_addr;
  logic                  bank_we;
  logic [DATA_WIDTH-1:0] bank_din;
  logic [NUM_BANKS-1:0]  bank_en;
  logic [DATA_WIDTH-1:0] bank_dout [NUM_BANKS];
  logic                  v1_q;
  logic [BANK_W-1:0]     sel1_q;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.clear_req) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + OFS_W'(1);
        if (cnt_q == OFS_W'(BANK_DEPTH - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign clearing = (state_q == CLEAR);
  assign accept   = bus.en && (state_q == IDLE);

  if (NUM_BANKS > 1) begin : g_sel
    assign bank_sel = bus.addr[ADDR_WIDTH-1:OFS_W];
  end else begin : g_nosel
    assign bank_sel = '0;
  end

  // The clear engine owns every bank's port while it runs; user accesses are refused then.
  assign bank_addr = clearing ? cnt_q : bus.addr[OFS_W-1:0];
  assign bank_we   = clearing | bus.we;
  assign bank_din  = clearing ? CLEAR_VALUE : bus.din;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign bank_en[b] = clearing || (accept && (bank_sel == BANK_W'(b)));

    bram_bank_core #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (BANK_DEPTH),
      .READ_MODE  (READ_MODE)
    ) u_core (
      .clk    (clk),
      .en_i   (bank_en[b]),
      .we_i   (bank_we),
      .addr_i (bank_addr),
      .din_i  (bank_din),
      .dout_o (bank_dout[b])
    );
  end

  assign rd_data = bank_dout[sel1_q];

  // out_q doubles as the hold register, so clear writes landing in the banks never reach dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      sel1_q <= '0;
      out_q  <= '0;
    end else begin
      v1_q <= accept && !(bus.we && (READ_MODE == NO_CHANGE));
      if (accept) begin
        sel1_q <= bank_sel;
      end
      if (v1_q) begin
        out_q <= rd_data;
      end
    end
  end

  if (OUT_REG) begin : g_oreg
    logic v2_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v2_q <= 1'b0;
      end else begin
        v2_q <= v1_q;
      end
    end

    assign bus.dout       = out_q;
    assign bus.dout_valid = v2_q;
  end else begin : g_noreg
    assign bus.dout       = v1_q ? rd_data : out_q;
    assign bus.dout_valid = v1_q;
  end

  assign bus.ready      = (state_q == IDLE);
  assign bus.clear_busy = (state_q != IDLE);
  assign bus.clear_done = (state_q == DONE);

endmodule

// File: tb/tb_bram_bank_array.sv
// tb/tb_bram_bank_array.sv - bench for bram_bank_array: three read modes side by side, scoreboarded
module tb_bram_bank_array;

  localparam int BANK_DEPTH = 16;
  localparam int NUM_BANKS  = 4;
  localparam int WORDS      = BANK_DEPTH * NUM_BANKS;
  localparam int AW         = 6;
  localparam int M_IDLE     = 0;
  localparam int M_CLEAR    = 1;
  localparam int M_DONE     = 2;
  localparam int MODE [3]   = '{0, 1, 2};
  localparam int OREG [3]   = '{1, 1, 0};
  localparam logic [7:0] CV [3] = '{8'h00, 8'hFF, 8'h00};

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [7:0]    din = '0;
  logic          clear_req = 1'b0;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         m_state = M_CLEAR;
  int         m_cnt = 0;
  int         done_cnt = 0;
  bit         started = 1'b0;
  logic [7:0] mem_m [3][WORDS];
  logic [7:0] m_last [3];
  exp_t       sbq [3][$];

  bram_bank_array_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(8)) ifc0 ();
  bram_bank_array_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(8)) ifc1 ();
  bram_bank_array_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(8)) ifc2 ();

  assign ifc0.en = en;  assign ifc0.we = we;  assign ifc0.addr = addr;
  assign ifc0.din = din;  assign ifc0.clear_req = clear_req;
  assign ifc1.en = en;  assign ifc1.we = we;  assign ifc1.addr = addr;
  assign ifc1.din = din;  assign ifc1.clear_req = clear_req;
  assign ifc2.en = en;  assign ifc2.we = we;  assign ifc2.addr = addr;
  assign ifc2.din = din;  assign ifc2.clear_req = clear_req;

  bram_bank_array #(
    .DATA_WIDTH(8), .BANK_DEPTH(BANK_DEPTH), .NUM_BANKS(NUM_BANKS),
    .READ_MODE(bram_pkg::WRITE_FIRST), .OUT_REG(1'b1), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'h00)
  ) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(ifc0));

  bram_bank_array #(
    .DATA_WIDTH(8), .BANK_DEPTH(BANK_DEPTH), .NUM_BANKS(NUM_BANKS),
    .READ_MODE(bram_pkg::READ_FIRST), .OUT_REG(1'b1), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'hFF)
  ) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1));

  bram_bank_array #(
    .DATA_WIDTH(8), .BANK_DEPTH(BANK_DEPTH), .NUM_BANKS(NUM_BANKS),
    .READ_MODE(bram_pkg::NO_CHANGE), .OUT_REG(1'b0), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'h00)
  ) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(ifc2));

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_exp(input int d, input logic [7:0] data);
    exp_t e;
    e.data = data;
    e.cyc  = cyc + OREG[d];
    sbq[d].push_back(e);
  endtask

  // Reference model: advances on every rising edge from the stimulus alone.
  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      case (m_state)
        M_IDLE: begin
          if (en) begin
            for (int d = 0; d < 3; d++) begin
              if (!we) begin
                push_exp(d, mem_m[d][addr]);
              end else begin
                if (MODE[d] == 0) push_exp(d, din);
                else if (MODE[d] == 1) push_exp(d, mem_m[d][addr]);
                mem_m[d][addr] = din;
              end
            end
          end
          if (clear_req) m_state = M_CLEAR;
        end
        M_CLEAR: begin
          for (int d = 0; d < 3; d++)
            for (int b = 0; b < NUM_BANKS; b++)
              mem_m[d][b * BANK_DEPTH + m_cnt] = CV[d];
          if (m_cnt == BANK_DEPTH - 1) begin
            m_state = M_DONE;
            m_cnt   = 0;
          end else begin
            m_cnt++;
          end
        end
        default: m_state = M_IDLE;
      endcase
    end
  end

  task automatic mon(input int d, input logic [7:0] dout, input logic dv,
                     input logic rdy, input logic busy, input logic done);
    logic has;
    exp_t e;
    check($sformatf("d%0d_ready", d), rdy, m_state == M_IDLE);
    check($sformatf("d%0d_busy", d), busy, m_state != M_IDLE);
    check($sformatf("d%0d_done", d), done, m_state == M_DONE);
    has = (sbq[d].size() > 0) && (sbq[d][0].cyc == cyc);
    check($sformatf("d%0d_dout_valid", d), dv, has);
    if (has) begin
      e = sbq[d].pop_front();
      m_last[d] = e.data;
    end
    check($sformatf("d%0d_dout", d), dout, m_last[d]);
  endtask

  always @(negedge clk) begin
    if (started) begin
      mon(0, ifc0.dout, ifc0.dout_valid, ifc0.ready, ifc0.clear_busy, ifc0.clear_done);
      mon(1, ifc1.dout, ifc1.dout_valid, ifc1.ready, ifc1.clear_busy, ifc1.clear_done);
      mon(2, ifc2.dout, ifc2.dout_valid, ifc2.ready, ifc2.clear_busy, ifc2.clear_done);
      if (ifc0.clear_done) done_cnt++;
    end
  end

  task automatic drive(input logic e, input logic w, input logic [AW-1:0] a,
                       input logic [7:0] dt, input logic cr);
    en = e; we = w; addr = a; din = dt; clear_req = cr;
    @(posedge clk);
    #1;
    en = 1'b0; we = 1'b0; clear_req = 1'b0;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    started = 1'b1;
    m_state = M_CLEAR;
    m_cnt   = 0;
    for (int d = 0; d < 3; d++) begin
      sbq[d].delete();
      m_last[d] = 8'h00;
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (ifc0.ready === 1'b1 || n >= 200) break;
      n++;
    end
  endtask

  int n;

  initial begin
    #3;
    do_reset();
    release_reset();
    wait_ready(n);
    check("rst_clear_len", n, BANK_DEPTH + 1);

    for (int i = 0; i < WORDS; i++) drive(1'b1, 1'b0, AW'(i), 8'h00, 1'b0);
    repeat (3) drive(1'b0, 1'b0, '0, 8'h00, 1'b0);

    drive(1'b1, 1'b1, 6'h13, 8'hA5, 1'b0);
    drive(1'b1, 1'b0, 6'h13, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 6'h03, 8'h00, 1'b0);
    repeat (3) drive(1'b0, 1'b0, '0, 8'h00, 1'b0);

    drive(1'b1, 1'b1, 6'h25, 8'h11, 1'b0);
    drive(1'b0, 1'b0, '0, 8'h00, 1'b0);
    drive(1'b1, 1'b1, 6'h25, 8'h22, 1'b0);
    drive(1'b1, 1'b0, 6'h25, 8'h00, 1'b0);
    repeat (3) drive(1'b0, 1'b0, '0, 8'h00, 1'b0);

    for (int i = 0; i < 120; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            AW'($urandom_range(0, WORDS - 1)), 8'($urandom_range(0, 255)), 1'b0);

    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, AW'(i), 8'h00, i == 4);
    wait_ready(n);
    check("stream_clear_len", n, BANK_DEPTH - 4);
    for (int i = 0; i < WORDS; i++) drive(1'b1, 1'b0, AW'(i), 8'h00, 1'b0);
    repeat (3) drive(1'b0, 1'b0, '0, 8'h00, 1'b0);

    done_cnt = 0;
    drive(1'b0, 1'b0, '0, 8'h00, 1'b1);
    repeat (3) drive(1'b0, 1'b0, '0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, '0, 8'h00, 1'b1);
    wait_ready(n);
    check("reclear_len", n, BANK_DEPTH - 3);
    check("done_once", done_cnt, 1);

    drive(1'b0, 1'b0, '0, 8'h00, 1'b1);
    repeat (5) drive(1'b0, 1'b0, '0, 8'h00, 1'b0);
    do_reset();
    release_reset();
    wait_ready(n);
    check("abort_clear_len", n, BANK_DEPTH + 1);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, AW'(i * 8), 8'h00, 1'b0);

    repeat (4) drive(1'b0, 1'b0, '0, 8'h00, 1'b0);
    for (int d = 0; d < 3; d++) check($sformatf("d%0d_sb_empty", d), sbq[d].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
